// File: rtl/instr_decompressor_if.sv
// rtl/instr_decompressor_if.sv - fetch-side, CPU-side, flush and dictionary-write signals of instr_decompressor
interface instr_decompressor_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_word;
  logic             in_compressed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_instr;
  logic             branch;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [WIDTH-1:0] tbl_data;

  modport master (
    output in_valid, in_word, in_compressed, out_ready, branch, tbl_we, tbl_addr, tbl_data,
    input  in_ready, out_valid, out_instr
  );

  modport slave (
    input  in_valid, in_word, in_compressed, out_ready, branch, tbl_we, tbl_addr, tbl_data,
    output in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/instr_decompressor.sv
// rtl/instr_decompressor.sv - expands raw/compressed fetch words into instructions via a dictionary table
module instr_decompressor #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  instr_decompressor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOOK0, LOOK1, OUT} state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_instr_q;
  logic             sv_q;
  logic [IDX_W-1:0] idx1_q;
  logic [WIDTH-1:0] tbl_q [2**IDX_W];
  logic [WIDTH-1:0] rd_data_q;
  logic [IDX_W-1:0] rd_addr_d;

  assign bus.in_ready  = (state_q == IDLE) && !reset && !bus.branch;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;

  // The table is read every cycle; the address only matters on the edge that leaves IDLE
  // (idx0 of the incoming word) or leaves OUT (the pending idx1).
  assign rd_addr_d = (state_q == OUT) ? idx1_q : bus.in_word[2*IDX_W-1:IDX_W];

  always_ff @(posedge clk) begin
    if (bus.tbl_we && !reset) begin
      tbl_q[bus.tbl_addr] <= bus.tbl_data;
    end
    rd_data_q <= tbl_q[rd_addr_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      sv_q        <= 1'b0;
      idx1_q      <= '0;
    end else if (bus.branch) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      sv_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.in_compressed) begin
              idx1_q  <= bus.in_word[IDX_W-1:0];
              sv_q    <= bus.in_word[2*IDX_W];
              state_q <= LOOK0;
            end else begin
              out_instr_q <= bus.in_word;
              out_valid_q <= 1'b1;
              state_q     <= OUT;
            end
          end
        end
        LOOK0, LOOK1: begin
          out_instr_q <= rd_data_q;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (sv_q) begin
              sv_q    <= 1'b0;
              state_q <= LOOK1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_decompressor.sv
// tb/tb_instr_decompressor.sv - self-checking bench for instr_decompressor
module tb_instr_decompressor;
  logic clk = 1'b0;
  logic reset;

  instr_decompressor_if #(.WIDTH(32), .IDX_W(8)) bus ();

  instr_decompressor #(.WIDTH(32), .IDX_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        comp;
    int          nbeats;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] dict [256];
  logic [31:0] q [$];
  int          nvec = 0;
  int          nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic tbl_write(input logic [7:0] a, input logic [31:0] d);
    bus.tbl_we = 1'b1; bus.tbl_addr = a; bus.tbl_data = d;
    dict[a] = d;
    tick();
    bus.tbl_we = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int t;
    int lat;
    bus.in_word = v.word; bus.in_compressed = v.comp; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    t = 0;
    while (!bus.in_ready && t < 20) begin tick(); t++; end
    check($sformatf("v%0d_in_ready", k), 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int b = 0; b < v.nbeats; b++) begin
      lat = 1;
      while (!bus.out_valid && lat < 20) begin tick(); lat++; end
      check($sformatf("v%0d_b%0d_latency", k, b), lat, (b == 0 && !v.comp) ? 32'd1 : 32'd2);
      check($sformatf("v%0d_b%0d_instr", k, b), bus.out_instr, (b == 0) ? v.e0 : v.e1);
      tick();
    end
    check($sformatf("v%0d_idle_after", k), {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
  endtask

  // Reference: a queue of instructions still owed to the CPU, filled from the dictionary rules.
  task automatic model_step();
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) check("rnd_spurious_beat", 32'd1, 32'd0);
      else check("rnd_beat", bus.out_instr, q.pop_front());
    end
    if (bus.branch) check("rnd_ready_in_branch", 32'(bus.in_ready), 32'd0);
    if (bus.in_ready) check("rnd_ready_while_busy", q.size(), 32'd0);
    if (bus.branch) q.delete();
    if (bus.in_valid && bus.in_ready) begin
      if (!bus.in_compressed) q.push_back(bus.in_word);
      else begin
        q.push_back(dict[bus.in_word[15:8]]);
        if (bus.in_word[16]) q.push_back(dict[bus.in_word[7:0]]);
      end
    end
  endtask

  initial begin
    int t;
    int seen;
    vecs[0] = '{32'hDEADBEEF, 1'b0, 1, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{32'h00010307, 1'b1, 2, 32'h00A00093, 32'h00B00113};
    vecs[2] = '{32'h00000300, 1'b1, 1, 32'h00A00093, 32'h0};
    vecs[3] = '{32'hFFFE0703, 1'b1, 1, 32'h00B00113, 32'h0};
    vecs[4] = '{32'hABC10703, 1'b1, 2, 32'h00B00113, 32'h00A00093};
    vecs[5] = '{32'h00000000, 1'b0, 1, 32'h00000000, 32'h0};
    vecs[6] = '{32'h00000900, 1'b1, 1, 32'h11111111, 32'h0};

    reset = 1'b1;
    bus.in_valid = 1'b1; bus.in_word = 32'h12345678; bus.in_compressed = 1'b0;
    bus.out_ready = 1'b0; bus.branch = 1'b0;
    bus.tbl_we = 1'b0; bus.tbl_addr = '0; bus.tbl_data = '0;

    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_instr", bus.out_instr, 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    reset = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("rst_release_ready", 32'(bus.in_ready), 32'd1);
    tick();

    tbl_write(8'd3, 32'h00A00093);
    tbl_write(8'd7, 32'h00B00113);
    tbl_write(8'd9, 32'h11111111);

    // A table write while reset is high must be dropped.
    reset = 1'b1; bus.tbl_we = 1'b1; bus.tbl_addr = 8'd9; bus.tbl_data = 32'h22222222;
    tick();
    reset = 1'b0; bus.tbl_we = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // Backpressure on the first beat of a pair.
    bus.in_word = 32'h00010307; bus.in_compressed = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 10) begin tick(); t++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", 32'(bus.out_valid), 32'd1);
      check("bp_instr_held", bus.out_instr, 32'h00A00093);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    t = 1;
    while (!bus.out_valid && t < 10) begin tick(); t++; end
    check("bp_second_latency", t, 32'd2);
    check("bp_second_instr", bus.out_instr, 32'h00B00113);
    tick();
    check("bp_ready_after", 32'(bus.in_ready), 32'd1);

    // Branch while the first beat is stalled.
    bus.in_word = 32'h00010307; bus.in_compressed = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 10) begin tick(); t++; end
    check("br_stalled_instr", bus.out_instr, 32'h00A00093);
    bus.branch = 1'b1;
    #1;
    check("br_ready_forced_low", 32'(bus.in_ready), 32'd0);
    tick();
    bus.branch = 1'b0;
    #1;
    check("br_out_valid_cleared", 32'(bus.out_valid), 32'd0);
    check("br_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) seen = 1;
      tick();
    end
    check("br_second_suppressed", seen, 32'd0);
    run_vec(7, '{32'hCAFEF00D, 1'b0, 1, 32'hCAFEF00D, 32'h0});

    // Randomized traffic with random flushes against the queue model.
    for (int a = 0; a < 256; a++) tbl_write(a[7:0], $urandom);
    q.delete();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid      = ($urandom_range(0, 3) != 0);
      bus.in_word       = $urandom;
      bus.in_compressed = $urandom_range(0, 1) == 1;
      bus.out_ready     = ($urandom_range(0, 3) != 0);
      bus.branch        = ($urandom_range(0, 19) == 0);
      #1;
      model_step();
      tick();
    end
    bus.in_valid = 1'b0; bus.branch = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      model_step();
      tick();
    end
    check("rnd_drain_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
